// File: rtl/toy_arb_pkg.sv
// Shared types and constants for the RISC_TOY memory arbiter.
// Holds the FSM states, grant encodings, abort pattern and the grant-selection helper.
package toy_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } arb_gnt_e;

   localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

   // With rr set, a contested grant goes to whichever side did not win last time.
   function automatic arb_gnt_e pick_grant(
      input logic     ireq,
      input logic     dreq,
      input logic     rr,
      input arb_gnt_e last
   );
      if (ireq && dreq && rr) begin
         return (last == GNT_D) ? GNT_I : GNT_D;
      end
      return dreq ? GNT_D : GNT_I;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for the memory arbiter: cleared when a transaction starts,
// bumped on every cycle the memory has not acknowledged.
module mem_arb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (inc) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires on the cycle whose increment would bring the count up to TIMEOUT.
   assign expired = inc && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/toy_mem_arbiter.sv
// Shares one single-port memory between the RISC_TOY fetch (I) and data (D) ports.
// Define ARB_RR_EN for round-robin arbitration; otherwise D always beats I.
module toy_mem_arbiter #(
   parameter int AW      = 30,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IACK,
   output logic [DW-1:0] IRDATA,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [AW-1:0] DADDR,
   input  logic [DW-1:0] DWDATA,
   output logic          DACK,
   output logic [DW-1:0] DRDATA,
   output logic          MREQ,
   output logic          MRW,
   output logic [AW-1:0] MADDR,
   output logic [DW-1:0] MWDATA,
   input  logic          MACK,
   input  logic [DW-1:0] MRDATA,
   output logic          STALL,
   output logic          ERR
);

   import toy_arb_pkg::*;

   arb_state_e    state_q,  state_d;
   arb_gnt_e      gnt_q,    gnt_d;
   logic [AW-1:0] maddr_q,  maddr_d;
   logic          mrw_q,    mrw_d;
   logic [DW-1:0] mwdata_q, mwdata_d;
   logic [DW-1:0] resp_q,   resp_d;
   logic          err_q,    err_d;
   arb_gnt_e      win;
   logic          timer_clr;
   logic          timer_inc;
   logic          timer_expired;

`ifdef ARB_RR_EN
   arb_gnt_e      last_q,   last_d;

   assign win = pick_grant(IREQ, DREQ, 1'b1, last_q);

   always_comb begin
      last_d = last_q;
      if ((state_q == IDLE) && (IREQ || DREQ)) begin
         last_d = win;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_q <= GNT_I;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign win = pick_grant(IREQ, DREQ, 1'b0, GNT_I);
`endif

   assign timer_clr = (state_q == IDLE) && (IREQ || DREQ);
   assign timer_inc = (state_q == BUSY) && !MACK;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .clr     (timer_clr),
      .inc     (timer_inc),
      .expired (timer_expired)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      maddr_d  = maddr_q;
      mrw_d    = mrw_q;
      mwdata_d = mwdata_q;
      resp_d   = resp_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (IREQ || DREQ) begin
               state_d  = BUSY;
               gnt_d    = win;
               maddr_d  = (win == GNT_D) ? DADDR : IADDR;
               mrw_d    = (win == GNT_D) && DRW;
               mwdata_d = (win == GNT_D) ? DWDATA : '0;
            end
         end
         BUSY: begin
            // A late MACK coinciding with expiry still returns real data.
            if (MACK) begin
               resp_d  = MRDATA;
               state_d = RESP;
            end else if (timer_expired) begin
               resp_d  = DW'(ABORT_DATA);
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_I;
         maddr_q  <= '0;
         mrw_q    <= 1'b0;
         mwdata_q <= '0;
         resp_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         maddr_q  <= maddr_d;
         mrw_q    <= mrw_d;
         mwdata_q <= mwdata_d;
         resp_q   <= resp_d;
         err_q    <= err_d;
      end
   end

   assign MREQ   = (state_q == BUSY);
   assign MRW    = mrw_q;
   assign MADDR  = maddr_q;
   assign MWDATA = mwdata_q;
   assign IACK   = (state_q == RESP) && (gnt_q == GNT_I);
   assign DACK   = (state_q == RESP) && (gnt_q == GNT_D);
   assign IRDATA = resp_q;
   assign DRDATA = resp_q;
   assign ERR    = err_q;
   assign STALL  = (IREQ && !IACK) || (DREQ && !DACK);

endmodule
